uart_tx_arb: RTL and testbench
==============================

Name: uart_tx_arb

Overview:
Round-robin arbiter and frame scheduler that shares one uart_tx serializer among N_REQ byte requesters. It accepts bytes over per-requester valid/ready handshakes and issues one-cycle start pulses with the selected byte. It paces frames by its own counter, because uart_tx has no busy output. It sits between the command/packet sources and uart_tx (start/data inputs) and supports packet locking, so that multi-byte messages are not interleaved.

Parameters:
N_REQ, 4, number of requesters (2..8)
FRAME_CYCLES, 10, clk cycles uart_tx needs per frame, measured start-pulse to next accepted start (start bit + 8 data + 1 stop); must be >= 10
GAP_CYCLES, 0, extra idle-high cycles inserted between frames (0..255)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
req_valid  in  N_REQ  requester i has a byte
req_data  in  8*N_REQ  byte of requester i at bits [8i+7:8i]
req_last  in  N_REQ  byte is the final byte of requester i's packet
req_ready  out  N_REQ  one-hot; byte accepted in a cycle where req_valid[i] & req_ready[i]
tx_start  out  1  one-cycle start pulse to uart_tx.start (registered)
tx_data  out  8  byte to uart_tx.data (registered, valid while tx_start=1)
busy  out  1  high whenever state != IDLE
grant_id  out  3  index of the last accepted requester
locked  out  1  grant locked to grant_id (packet in progress)

Behaviour:
- Reset values: state IDLE, tx_start 0, tx_data 0, req_ready 0, grant_id 0, locked 0, rr pointer 0, pace counter 0. Reset mid-frame aborts immediately; no pending byte is retained.
- States:
  - IDLE: accept a byte.
  - START: tx_start=1 for exactly one cycle.
  - WAIT: count FRAME_CYCLES+GAP_CYCLES-2 cycles, then return to IDLE.
- IDLE, unlocked:
  - Candidate = first i with req_valid[i], searching from (grant_id+1) mod N_REQ upward, wrapping. After reset the search starts at index 0.
  - req_ready[candidate]=1, combinational from req_valid. All other req_ready bits are 0. If no requester is valid, stay in IDLE with req_ready=0.
- IDLE, locked: only requester grant_id is eligible. Others get req_ready=0 even if it is not valid; the block waits indefinitely.
- On accept (cycle A), at the next edge:
  - tx_data <= req_data[grant], tx_start <= 1, grant_id <= i.
  - locked <= ~req_last[i].
  - State goes to START, so tx_start is high in cycle A+1.
- START -> WAIT unconditionally. WAIT -> IDLE when the pace counter expires.
- Throughput: with continuous valid, tx_start pulses are spaced exactly FRAME_CYCLES+GAP_CYCLES cycles apart, i.e. 10 with defaults. This matches uart_tx returning to idle after its stop bit.
- Latency: accept in cycle A -> tx_start in A+1 -> uart miso start bit (0) in A+2, data LSB first in A+3..A+10, stop (1) in A+11.
- req_ready is never asserted in START or WAIT. Valid may rise or fall at any time; only the accept cycle matters.
- A req_last=1 byte clears locked. A single byte with req_last=1 from an unlocked requester never locks.
- Simultaneous valids: exactly one is granted per IDLE cycle; no requester waits more than N_REQ-1 frames when unlocked.
- The rr pointer wraps from N_REQ-1 to 0.

Test Plan:
- Single byte: req_valid[0]=1, data 0xA5, last=1 -> req_ready[0] one cycle; tx_start one cycle later with tx_data=0xA5; uart miso = 0,1,0,1,0,0,1,0,1,1; locked stays 0.
- Fairness: all 4 valid and continuous, last=1 each -> grant order 0,1,2,3,0; tx_start pulses exactly 10 cycles apart.
- Packet lock: req 1 sends 0x11 (last=0), 0x22 (last=0), 0x33 (last=1) while req 2 is valid -> the three bytes go back-to-back to req 1, then req 2 is granted; locked is 1 between the first and last bytes.
- Gap: GAP_CYCLES=3, two requesters valid -> tx_start spacing 13 cycles; miso high for 4 cycles between frames.
- Locked stall: req 0 sends last=0 then drops valid; req 3 valid -> req_ready stays 0 and no tx_start for 50 cycles; req 0 sends last=1 -> resumes, req 3 granted next.
- Reset mid-frame: assert rst_n low during WAIT -> tx_start=0, busy=0, locked=0 immediately; after release, first grant goes to the lowest valid index.

Source files
------------

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that feeds one uart_tx serializer from N_REQ byte requesters.
// Frames are paced by an internal counter, and a packet lock keeps multi-byte messages contiguous.
module uart_tx_arb #(
    parameter int N_REQ        = 4,
    parameter int FRAME_CYCLES = 10,
    parameter int GAP_CYCLES   = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    output logic               busy,
    output logic [2:0]         grant_id,
    output logic               locked
);

    // START takes one cycle and the IDLE accept cycle takes one, so WAIT covers the rest of the frame
    localparam int WAIT_CYCLES = FRAME_CYCLES + GAP_CYCLES - 2;
    localparam int CW          = $clog2(WAIT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t        state, next_state;
    logic [2:0]    rr_ptr;
    logic [CW-1:0] pace_cnt;

    logic [7:0]    valid8;
    logic [7:0]    last8;
    logic [63:0]   data64;
    logic [7:0]    ready8;
    logic          cand_found;
    logic [2:0]    cand_idx;
    logic [2:0]    sel;
    logic          accept;
    logic [2:0]    next_rr;

    assign valid8 = 8'(req_valid);
    assign last8  = 8'(req_last);
    assign data64 = 64'(req_data);

    // Rotating priority search beginning at rr_ptr, which always points one past the last grant
    always_comb begin
        int idx;
        cand_found = 1'b0;
        cand_idx   = 3'd0;
        idx        = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!cand_found && valid8[3'(idx)]) begin
                cand_found = 1'b1;
                cand_idx   = 3'(idx);
            end
        end
    end

    always_comb begin
        sel    = locked ? grant_id : cand_idx;
        accept = (state == IDLE) && (locked ? valid8[grant_id] : cand_found);
        ready8 = 8'd0;
        if (accept) begin
            ready8[sel] = 1'b1;
        end
        req_ready = ready8[N_REQ-1:0];
        next_rr   = (sel == 3'(N_REQ - 1)) ? 3'd0 : sel + 3'd1;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = START;
            START:   next_state = WAIT;
            WAIT:    if (pace_cnt == '0) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_data  <= 8'd0;
            grant_id <= 3'd0;
            locked   <= 1'b0;
            rr_ptr   <= 3'd0;
            pace_cnt <= '0;
        end else begin
            state    <= next_state;
            tx_start <= accept;
            if (accept) begin
                tx_data  <= data64[{sel, 3'b000} +: 8];
                grant_id <= sel;
                locked   <= ~last8[sel];
                rr_ptr   <= next_rr;
            end
            if (state == START) begin
                pace_cnt <= CW'(WAIT_CYCLES - 1);
            end else if (state == WAIT && pace_cnt != '0) begin
                pace_cnt <= pace_cnt - 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: default instance plus a GAP_CYCLES=3 instance,
// each followed by a small uart_tx line model for start/data/stop timing checks.
module tb_uart_tx_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        busy;
    logic [2:0]  grant_id;
    logic        locked;

    logic [3:0]  g_valid = '0;
    logic [31:0] g_data = '0;
    logic [3:0]  g_last = '0;
    logic [3:0]  g_ready;
    logic        g_tx_start;
    logic [7:0]  g_tx_data;
    logic        g_busy;
    logic [2:0]  g_grant_id;
    logic        g_locked;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    uart_tx_arb dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start),
        .tx_data(tx_data), .busy(busy), .grant_id(grant_id), .locked(locked)
    );

    uart_tx_arb #(.N_REQ(4), .FRAME_CYCLES(10), .GAP_CYCLES(3)) dut_gap (
        .clk(clk), .rst_n(rst_n), .req_valid(g_valid), .req_data(g_data),
        .req_last(g_last), .req_ready(g_ready), .tx_start(g_tx_start),
        .tx_data(g_tx_data), .busy(g_busy), .grant_id(g_grant_id), .locked(g_locked)
    );

    // Line models of uart_tx: start bit the cycle after the pulse, 8 data bits LSB first, then stop
    logic       miso = 1'b1;
    logic [8:0] sh = '0;
    int         bits = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso <= 1'b1; bits <= 0;
        end else if (tx_start) begin
            sh <= {1'b1, tx_data}; miso <= 1'b0; bits <= 9;
        end else if (bits != 0) begin
            miso <= sh[0]; sh <= sh >> 1; bits <= bits - 1;
        end else begin
            miso <= 1'b1;
        end
    end

    logic       g_miso = 1'b1;
    logic [8:0] g_sh = '0;
    int         g_bits = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_miso <= 1'b1; g_bits <= 0;
        end else if (g_tx_start) begin
            g_sh <= {1'b1, g_tx_data}; g_miso <= 1'b0; g_bits <= 9;
        end else if (g_bits != 0) begin
            g_miso <= g_sh[0]; g_sh <= g_sh >> 1; g_bits <= g_bits - 1;
        end else begin
            g_miso <= 1'b1;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0; req_data = '0; req_last = '0;
        g_valid = '0; g_data = '0; g_last = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_start(input int limit, output bit found);
        found = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (tx_start) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_g_start(input int limit, output bit found);
        found = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (g_tx_start) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '0; req_data = '0; req_last = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_start, tx_data, req_ready, grant_id, locked, busy} !== 18'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: got start=%b data=%h ready=%b grant=%0d locked=%b busy=%b expected all zero",
                     tx_start, tx_data, req_ready, grant_id, locked, busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_byte();
        logic [9:0] exp_bits;
        exp_bits = 10'b1101001010;
        do_reset();
        req_valid = 4'b0001; req_data[7:0] = 8'hA5; req_last = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("[TB] FAIL single_ready: got %b expected 0001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'hA5 || locked !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_start: got start=%b data=%h locked=%b busy=%b expected 1 a5 0 1",
                     tx_start, tx_data, locked, busy);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (miso !== exp_bits[k] || tx_start !== 1'b0 || req_ready !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL single_line bit %0d: got miso=%b start=%b ready=%b expected miso=%b start=0 ready=0",
                         k, miso, tx_start, req_ready, exp_bits[k]);
            end
        end
    endtask

    task automatic test_fairness();
        bit found;
        int prev;
        prev = 0;
        do_reset();
        req_valid = 4'hF; req_data = 32'h13121110; req_last = 4'hF;
        for (int n = 0; n < 5; n++) begin
            wait_start(20, found);
            checks++;
            if (!found) begin
                errors++; $display("[TB] FAIL fair_timeout frame %0d: got no tx_start expected one", n);
            end else if (grant_id !== 3'(n % 4) || tx_data !== 8'(8'h10 + n % 4)) begin
                errors++;
                $display("[TB] FAIL fair_grant frame %0d: got grant=%0d data=%h expected grant=%0d data=%h",
                         n, grant_id, tx_data, n % 4, 8'h10 + n % 4);
            end
            if (n > 0) begin
                checks++;
                if (cyc - prev !== 10) begin
                    errors++; $display("[TB] FAIL fair_spacing frame %0d: got %0d expected 10", n, cyc - prev);
                end
            end
            prev = cyc;
        end
        req_valid = '0;
    endtask

    task automatic test_packet_lock();
        bit found;
        do_reset();
        req_valid = 4'b0110; req_data = 32'h0099_1100; req_last = 4'b0100;
        wait_start(5, found);
        checks++;
        if (!found || tx_data !== 8'h11 || grant_id !== 3'd1 || locked !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lock_byte1: got found=%b data=%h grant=%0d locked=%b expected 1 11 1 1",
                     found, tx_data, grant_id, locked);
        end
        req_data[15:8] = 8'h22;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++; $display("[TB] FAIL lock_wait_ready: got %b expected 0000", req_ready);
        end
        wait_start(20, found);
        checks++;
        if (!found || tx_data !== 8'h22 || grant_id !== 3'd1 || locked !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lock_byte2: got found=%b data=%h grant=%0d locked=%b expected 1 22 1 1",
                     found, tx_data, grant_id, locked);
        end
        req_data[15:8] = 8'h33; req_last[1] = 1'b1;
        wait_start(20, found);
        checks++;
        if (!found || tx_data !== 8'h33 || grant_id !== 3'd1 || locked !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lock_byte3: got found=%b data=%h grant=%0d locked=%b expected 1 33 1 0",
                     found, tx_data, grant_id, locked);
        end
        req_valid[1] = 1'b0;
        wait_start(20, found);
        checks++;
        if (!found || tx_data !== 8'h99 || grant_id !== 3'd2) begin
            errors++;
            $display("[TB] FAIL lock_release: got found=%b data=%h grant=%0d expected 1 99 2",
                     found, tx_data, grant_id);
        end
        req_valid = '0;
    endtask

    task automatic test_locked_stall();
        bit found;
        int bad;
        bad = 0;
        do_reset();
        req_valid = 4'b1001; req_data = 32'h7700_0040; req_last = 4'b1000;
        wait_start(5, found);
        checks++;
        if (!found || grant_id !== 3'd0 || locked !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_first: got found=%b grant=%0d locked=%b expected 1 0 1", found, grant_id, locked);
        end
        req_valid[0] = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready !== 4'b0000 || tx_start !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0 || locked !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_hold: got %0d active cycles locked=%b expected 0 active locked=1", bad, locked);
        end
        req_valid[0] = 1'b1; req_data[7:0] = 8'h41; req_last[0] = 1'b1;
        wait_start(5, found);
        checks++;
        if (!found || tx_data !== 8'h41 || grant_id !== 3'd0 || locked !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_resume: got found=%b data=%h grant=%0d locked=%b expected 1 41 0 0",
                     found, tx_data, grant_id, locked);
        end
        req_valid[0] = 1'b0;
        wait_start(20, found);
        checks++;
        if (!found || tx_data !== 8'h77 || grant_id !== 3'd3) begin
            errors++;
            $display("[TB] FAIL stall_next: got found=%b data=%h grant=%0d expected 1 77 3", found, tx_data, grant_id);
        end
        req_valid = '0;
    endtask

    task automatic test_gap();
        bit found;
        int t0;
        do_reset();
        g_valid = 4'b0011; g_data = 32'h0000_5A3C; g_last = 4'b0011;
        wait_g_start(5, found);
        t0 = cyc;
        checks++;
        if (!found || g_tx_data !== 8'h3C || g_grant_id !== 3'd0) begin
            errors++;
            $display("[TB] FAIL gap_first: got found=%b data=%h grant=%0d expected 1 3c 0", found, g_tx_data, g_grant_id);
        end
        g_valid[0] = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k >= 10 && k <= 13) begin
                checks++;
                if (g_miso !== 1'b1) begin
                    errors++; $display("[TB] FAIL gap_idle offset %0d: got miso=%b expected 1", k, g_miso);
                end
            end
            if (k == 13) begin
                checks++;
                if (g_tx_start !== 1'b1 || cyc - t0 !== 13 || g_tx_data !== 8'h5A) begin
                    errors++;
                    $display("[TB] FAIL gap_spacing: got start=%b spacing=%0d data=%h expected 1 13 5a",
                             g_tx_start, cyc - t0, g_tx_data);
                end
            end
            if (k == 14) begin
                checks++;
                if (g_miso !== 1'b0) begin
                    errors++; $display("[TB] FAIL gap_start_bit: got miso=%b expected 0", g_miso);
                end
            end
        end
        g_valid = '0;
    endtask

    task automatic test_reset_mid_frame();
        bit found;
        do_reset();
        req_valid = 4'b0100; req_data = 32'h002F_0000; req_last = 4'b0000;
        wait_start(5, found);
        req_valid = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (!found || grant_id !== 3'd2 || locked !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_pre: got found=%b grant=%0d locked=%b busy=%b expected 1 2 1 1",
                     found, grant_id, locked, busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx_start !== 1'b0 || busy !== 1'b0 || locked !== 1'b0 || grant_id !== 3'd0) begin
            errors++;
            $display("[TB] FAIL midreset_clear: got start=%b busy=%b locked=%b grant=%0d expected 0 0 0 0",
                     tx_start, busy, locked, grant_id);
        end
        req_valid = 4'b1010; req_data = 32'h3300_1100; req_last = 4'b1010;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("[TB] FAIL midreset_ready: got %b expected 0010", req_ready);
        end
        wait_start(5, found);
        checks++;
        if (!found || grant_id !== 3'd1 || tx_data !== 8'h11) begin
            errors++;
            $display("[TB] FAIL midreset_grant: got found=%b grant=%0d data=%h expected 1 1 11", found, grant_id, tx_data);
        end
        req_valid = '0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_single_byte();
        test_fairness();
        test_packet_lock();
        test_locked_stall();
        test_gap();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
